// File: rtl/reg_file_if.sv
// reg_file_if
//   Bundles the decode/writeback-facing signals of reg_file_param.
//   master: pipeline side (drives reads, writes, PC control and issue).
//   slave : register file side (returns read data, PC, stall, scoreboard).
//   Signals:
//     read_en   [NUM_RD]         per-port read enable
//     src_add   [NUM_RD*ADDR_W]  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//     out_src   [NUM_RD*DATA_W]  packed read data,      port k at [k*DATA_W +: DATA_W]
//     write, dest_add, data_write  general register write
//     write_pc, pc_next, pc_advance  PC control
//     pc_data   [DATA_W]         registered PC value
//     issue, issue_dest          mark a destination as pending
//     stall                      read hazard on a pending register
//     pending   [2**ADDR_W]      registered scoreboard bits
interface reg_file_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int NUM_RD = 3
);
   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [NUM_RD-1:0]        read_en;
   logic [NUM_RD*ADDR_W-1:0] src_add;
   logic [NUM_RD*DATA_W-1:0] out_src;
   logic                     write;
   logic [ADDR_W-1:0]        dest_add;
   logic [DATA_W-1:0]        data_write;
   logic                     write_pc;
   logic [DATA_W-1:0]        pc_next;
   logic                     pc_advance;
   logic [DATA_W-1:0]        pc_data;
   logic                     issue;
   logic [ADDR_W-1:0]        issue_dest;
   logic                     stall;
   logic [NUM_REGS-1:0]      pending;

   modport master (
      output read_en, src_add, write, dest_add, data_write,
             write_pc, pc_next, pc_advance, issue, issue_dest,
      input  out_src, pc_data, stall, pending
   );

   modport slave (
      input  read_en, src_add, write, dest_add, data_write,
             write_pc, pc_next, pc_advance, issue, issue_dest,
      output out_src, pc_data, stall, pending
   );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param
//   Parametrised multi-port register file with write-to-read bypass, a
//   dedicated auto-advancing PC aliased at PC_INDEX, and a pending-write
//   scoreboard that raises stall for reads of registers still in flight.
//   Ports:
//     clock    rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      reg_file_if.slave (reads, writes, PC control, issue, status)
module reg_file_param #(
   parameter int              DATA_W         = 32,
   parameter int              ADDR_W         = 4,
   parameter int              NUM_RD         = 3,
   parameter int              PC_INDEX       = 15,
   parameter int              PC_STEP        = 4,
   parameter int              PC_READ_OFFSET = 8,
   parameter logic [DATA_W-1:0] RESET_PC     = '0
) (
   input  logic        clock,
   input  logic        reset_n,
   reg_file_if.slave   bus
);
   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_INDEX);

   // Entry PC_ADDR of regs is never written or read; the PC lives in pc_q.
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [DATA_W-1:0]   pc_q;
   logic [DATA_W-1:0]   pc_nxt;
   logic [NUM_REGS-1:0] pend_q;
   logic [NUM_REGS-1:0] pend_nxt;
   logic                wr_pc_idx;

   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic                     stall_c;

   assign wr_pc_idx = bus.write && (bus.dest_add == PC_ADDR);

   // Value the PC takes at the next edge; also the base for PC reads so
   // that a PC redirect in this cycle is bypassed to decode.
   // NOTE: every variable in an always_comb gets a default first so no path
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      pc_nxt = pc_q;
      if (bus.write_pc)
         pc_nxt = bus.pc_next;
      else if (wr_pc_idx)
         pc_nxt = bus.data_write;
      else if (bus.pc_advance)
         pc_nxt = pc_q + DATA_W'(PC_STEP);
   end

   // Clear on writeback first, then set on issue: a same-cycle issue to the
   // same register is the newer producer and must stay pending.
   always_comb begin
      pend_nxt = pend_q;
      if (bus.write)
         pend_nxt[bus.dest_add] = 1'b0;
      if (bus.issue)
         pend_nxt[bus.issue_dest] = 1'b1;
   end

   // Combinational read ports and hazard detection. A same-cycle writeback
   // to the source resolves the hazard because the bypass supplies the data.
   always_comb begin
      rd_data = '0;
      stall_c = 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
         logic [ADDR_W-1:0] src;
         logic              byp;
         src = bus.src_add[k*ADDR_W +: ADDR_W];
         byp = bus.write && (bus.dest_add == src);
         if (bus.read_en[k]) begin
            if (src == PC_ADDR)
               rd_data[k*DATA_W +: DATA_W] = pc_nxt + DATA_W'(PC_READ_OFFSET);
            else if (byp)
               rd_data[k*DATA_W +: DATA_W] = bus.data_write;
            else
               rd_data[k*DATA_W +: DATA_W] = regs[src];
            if (pend_q[src] && !byp)
               stall_c = 1'b1;
         end
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q   <= RESET_PC;
         pend_q <= '0;
      end else begin
         pc_q   <= pc_nxt;
         pend_q <= pend_nxt;
      end
   end

   // NOTE: the register array is reset because architectural state must read
   // as zero after reset; this keeps it in flops rather than a RAM macro.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NUM_REGS; r++)
            regs[r] <= '0;
      end else if (bus.write && !wr_pc_idx) begin
         regs[bus.dest_add] <= bus.data_write;
      end
   end

   assign bus.out_src = rd_data;
   assign bus.stall   = stall_c;
   assign bus.pc_data = pc_q;
   assign bus.pending = pend_q;
endmodule
